vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Generates raster timing for the VGA path: horizontal/vertical pixel counters, sync pulses, blanking and active-area pixel coordinates. Produces the H_Cont/V_Cont scan position consumed by every overlay renderer (digit/glyph displays, sprite layers). Sits between the pixel-clock enable and the overlay/colour mux feeding the DAC. Defaults are 640x480@60 with a 25 MHz pixel rate.

Parameters:
H_SYNC, 96, hsync pulse width in pixels
H_BACK, 48, horizontal back porch
H_ACTIVE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch
V_SYNC, 2, vsync pulse width in lines
V_BACK, 33, vertical back porch
V_ACTIVE, 480, visible lines per frame
V_FRONT, 10, vertical front porch
SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_pix_en  in  1  pixel-rate enable; counters advance only when high
o_H_Cont  out  13  horizontal counter, 0..H_TOTAL-1, 0 = first hsync pixel
o_V_Cont  out  13  vertical counter, 0..V_TOTAL-1, 0 = first vsync line
o_x  out  13  active-area column, 0..H_ACTIVE-1; 0 when blanked
o_y  out  13  active-area row, 0..V_ACTIVE-1; 0 when blanked
o_hsync  out  1  horizontal sync, level per SYNC_POL
o_vsync  out  1  vertical sync, level per SYNC_POL
o_blank_n  out  1  high only inside the active area
o_line_start  out  1  one-clock pulse when o_H_Cont becomes 0
o_frame_start  out  1  one-clock pulse when (o_H_Cont,o_V_Cont) becomes (0,0)

Behaviour:
- H_TOTAL = H_SYNC+H_BACK+H_ACTIVE+H_FRONT (800). V_TOTAL is the vertical analogue (525). All widths are 13-bit unsigned. Parameters must satisfy H_TOTAL, V_TOTAL < 8192.
- Reset (async, i_rst_n=0): H=0, V=0, o_x=0, o_y=0, o_hsync=o_vsync=SYNC_POL (asserted), o_blank_n=0, o_line_start=0, o_frame_start=0.
- All outputs are registered and mutually aligned. Each output is a function of the counter value it is presented with. Derive registered outputs from the next-state counter values, so there is no latency skew between the counters and sync, blank or coordinates.
- Cycle with i_pix_en=1: H increments. At H=H_TOTAL-1, H wraps to 0 and V increments. At V=V_TOTAL-1 with H wrapping, V wraps to 0.
- Cycle with i_pix_en=0: every output holds, except the pulses, which drop to 0.
- hsync is asserted for H in [0, H_SYNC-1]. vsync is asserted for V in [0, V_SYNC-1], with transitions aligned to H=0.
- Active area: H in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_ACTIVE-1] and V in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_ACTIVE-1].
  - Inside it: o_blank_n=1, o_x=H-(H_SYNC+H_BACK), o_y=V-(V_SYNC+V_BACK).
  - Outside it: o_blank_n=0, o_x=0, o_y=0.
- o_line_start is high for exactly one i_clk cycle, the cycle in which H first shows 0 after a wrap.
- o_frame_start is the same, additionally requiring V=0. Neither pulse is raised by reset release; the first frame_start comes after one full frame.
- Reset asserted mid-frame forces the reset values immediately. After release, counting restarts at (0,0) on the first enabled clock.
- i_pix_en held permanently high is legal and gives one pixel per clock.

Decomposition:
- Shared package vga_pkg holds the default timing constants, the derived H_TOTAL/V_TOTAL/H_ACT_START/V_ACT_START, and the 13-bit coordinate width. Overlay renderers import the same width from this package.
- One natural sub-module, vga_axis_counter. It is instantiated twice (horizontal and vertical) and contains:
  - wrap counter with enable
  - sync-window compare
  - active-window compare
  - offset subtraction
- The horizontal instance's wrap output enables the vertical instance.

Test Plan:
- Reset, then release with i_pix_en=1 -> H=0, V=0, hsync=vsync=0, blank_n=0 during reset. H=1 on the first clock after release, with no frame_start.
- 96 enabled clocks from H=0 -> hsync=0 for H=0..95 and 1 at H=96. blank_n first rises at H=144 (V in the active range) with o_x=0. o_x=639 at H=783, and blank_n=0 at H=784.
- Run a full frame -> line_start every 800 enabled clocks. frame_start after exactly 420000 enabled clocks, with V showing 0. vsync asserted for V=0,1 only. o_y=0 at V=35 and o_y=479 at V=514.
- i_pix_en toggled 1,0,1,0 -> counters advance every other clock and hold otherwise. line_start is asserted for a single i_clk only.
- Reset asserted at H=400, V=200 -> all outputs take reset values immediately, without waiting for a clock edge. Counting resumes from (0,0) after release.
- Non-default parameters (H 8/4/16/4, V 2/1/4/1, SYNC_POL=1) -> H_TOTAL=32 and V_TOTAL=8. Syncs are active-high. frame_start comes every 256 enabled clocks.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA raster constants: default 640x480@60 timing and the coordinate width
// used by the timing generator and every overlay renderer.
package vga_pkg;

  localparam int unsigned CoordW = 13;
  typedef logic [CoordW-1:0] coord_t;

  localparam int unsigned HSync   = 96;
  localparam int unsigned HBack   = 48;
  localparam int unsigned HActive = 640;
  localparam int unsigned HFront  = 16;

  localparam int unsigned VSync   = 2;
  localparam int unsigned VBack   = 33;
  localparam int unsigned VActive = 480;
  localparam int unsigned VFront  = 10;

  localparam int unsigned HTotal    = HSync + HBack + HActive + HFront;
  localparam int unsigned VTotal    = VSync + VBack + VActive + VFront;
  localparam int unsigned HActStart = HSync + HBack;
  localparam int unsigned VActStart = VSync + VBack;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with registered sync, plus next-state
// active-window flag and in-window offset for the parent to register.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned Sync     = HSync,
  parameter int unsigned ActStart = HActStart,
  parameter int unsigned Active   = HActive,
  parameter int unsigned Total    = HTotal,
  parameter bit          SyncPol  = 1'b0
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   en_i,
  output coord_t cnt_o,
  output logic   wrap_o,
  output logic   sync_o,
  output logic   act_d_o,
  output coord_t pos_d_o
);

  localparam coord_t LastC     = coord_t'(Total - 1);
  localparam coord_t SyncEndC  = coord_t'(Sync);
  localparam coord_t ActStartC = coord_t'(ActStart);
  localparam coord_t ActEndC   = coord_t'(ActStart + Active);

  coord_t cnt_q, cnt_d;
  logic   sync_q, sync_d;

  // Decode from cnt_d so registered sync/window outputs line up with the counter.
  always_comb begin
    wrap_o = en_i && (cnt_q == LastC);
    cnt_d  = cnt_q;
    if (en_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + coord_t'(1);
    end
    sync_d  = (cnt_d < SyncEndC) ? SyncPol : ~SyncPol;
    act_d_o = (cnt_d >= ActStartC) && (cnt_d < ActEndC);
    pos_d_o = act_d_o ? cnt_d - ActStartC : '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      sync_q <= SyncPol;
    end else begin
      cnt_q  <= cnt_d;
      sync_q <= sync_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign sync_o = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: horizontal/vertical counters, syncs, blanking, active-area
// coordinates and line/frame start pulses, all registered and mutually aligned.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_SYNC   = HSync,
  parameter int unsigned H_BACK   = HBack,
  parameter int unsigned H_ACTIVE = HActive,
  parameter int unsigned H_FRONT  = HFront,
  parameter int unsigned V_SYNC   = VSync,
  parameter int unsigned V_BACK   = VBack,
  parameter int unsigned V_ACTIVE = VActive,
  parameter int unsigned V_FRONT  = VFront,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_pix_en,
  output logic [CoordW-1:0] o_H_Cont,
  output logic [CoordW-1:0] o_V_Cont,
  output logic [CoordW-1:0] o_x,
  output logic [CoordW-1:0] o_y,
  output logic              o_hsync,
  output logic              o_vsync,
  output logic              o_blank_n,
  output logic              o_line_start,
  output logic              o_frame_start
);

  localparam int unsigned HTot = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int unsigned VTot = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

  logic   h_wrap, v_wrap, h_act_d, v_act_d;
  coord_t h_pos_d, v_pos_d;

  logic   blank_n_q, blank_n_d;
  coord_t x_q, x_d, y_q, y_d;
  logic   line_q, line_d, frame_q, frame_d;

  vga_axis_counter #(
    .Sync     (H_SYNC),
    .ActStart (H_SYNC + H_BACK),
    .Active   (H_ACTIVE),
    .Total    (HTot),
    .SyncPol  (SYNC_POL)
  ) u_h (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .en_i    (i_pix_en),
    .cnt_o   (o_H_Cont),
    .wrap_o  (h_wrap),
    .sync_o  (o_hsync),
    .act_d_o (h_act_d),
    .pos_d_o (h_pos_d)
  );

  // The vertical axis steps once per horizontal wrap, so vsync edges land on H=0.
  vga_axis_counter #(
    .Sync     (V_SYNC),
    .ActStart (V_SYNC + V_BACK),
    .Active   (V_ACTIVE),
    .Total    (VTot),
    .SyncPol  (SYNC_POL)
  ) u_v (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .en_i    (h_wrap),
    .cnt_o   (o_V_Cont),
    .wrap_o  (v_wrap),
    .sync_o  (o_vsync),
    .act_d_o (v_act_d),
    .pos_d_o (v_pos_d)
  );

  always_comb begin
    blank_n_d = h_act_d && v_act_d;
    x_d       = blank_n_d ? h_pos_d : '0;
    y_d       = blank_n_d ? v_pos_d : '0;
    line_d    = h_wrap;
    frame_d   = v_wrap;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      blank_n_q <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      line_q    <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      blank_n_q <= blank_n_d;
      x_q       <= x_d;
      y_q       <= y_d;
      line_q    <= line_d;
      frame_q   <= frame_d;
    end
  end

  assign o_blank_n     = blank_n_q;
  assign o_x           = x_q;
  assign o_y           = y_q;
  assign o_line_start  = line_q;
  assign o_frame_start = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 instance and a small 32x8 active-high
// instance, checked per clock against a scoreboard plus directed position checks.
module tb_vga_timing_gen;
  import vga_pkg::*;

  typedef struct {
    int hs; int hb; int ha; int hf;
    int vs; int vb; int va; int vf;
    bit pol;
  } tim_t;

  typedef struct {
    string tag;
    int h; int v; int x; int y;
    bit hs; bit vs; bit bn; bit ls; bit fs;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, en_a, rst_b, en_b;
  logic [CoordW-1:0] h_a, v_a, x_a, y_a, h_b, v_b, x_b, y_b;
  logic hs_a, vs_a, bn_a, ls_a, fs_a, hs_b, vs_b, bn_b, ls_b, fs_b;

  vga_timing_gen u_dut_a (
    .i_clk(clk), .i_rst_n(rst_a), .i_pix_en(en_a),
    .o_H_Cont(h_a), .o_V_Cont(v_a), .o_x(x_a), .o_y(y_a),
    .o_hsync(hs_a), .o_vsync(vs_a), .o_blank_n(bn_a),
    .o_line_start(ls_a), .o_frame_start(fs_a)
  );

  vga_timing_gen #(
    .H_SYNC(8), .H_BACK(4), .H_ACTIVE(16), .H_FRONT(4),
    .V_SYNC(2), .V_BACK(1), .V_ACTIVE(4), .V_FRONT(1), .SYNC_POL(1'b1)
  ) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_b), .i_pix_en(en_b),
    .o_H_Cont(h_b), .o_V_Cont(v_b), .o_x(x_b), .o_y(y_b),
    .o_hsync(hs_b), .o_vsync(vs_b), .o_blank_n(bn_b),
    .o_line_start(ls_b), .o_frame_start(fs_b)
  );

  tim_t T[2];
  int   m_h[2];
  int   m_v[2];
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;
  int   n_checks = 0;
  int   n_err = 0;
  int   en_cnt_a = 0, last_ls = 0, ls_cnt = 0;

  task automatic chk(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic cmp(input string who, input exp_t e, input int h, input int v, input int x,
                     input int y, input bit hs, input bit vs, input bit bn, input bit ls,
                     input bit fs);
    n_checks++;
    if (h != e.h || v != e.v || x != e.x || y != e.y || hs != e.hs || vs != e.vs ||
        bn != e.bn || ls != e.ls || fs != e.fs) begin
      n_err++;
      $display("FAIL %s/%s: got H=%0d V=%0d x=%0d y=%0d hs=%0b vs=%0b bn=%0b ls=%0b fs=%0b; want H=%0d V=%0d x=%0d y=%0d hs=%0b vs=%0b bn=%0b ls=%0b fs=%0b",
               who, e.tag, h, v, x, y, hs, vs, bn, ls, fs,
               e.h, e.v, e.x, e.y, e.hs, e.vs, e.bn, e.ls, e.fs);
    end
  endtask

  // Reference raster model: state after the coming clock edge.
  task automatic model_step(input int d, input bit rst, input bit en, input string tag);
    exp_t e;
    int ht, vt, hst, vst;
    bit wrap;
    ht  = T[d].hs + T[d].hb + T[d].ha + T[d].hf;
    vt  = T[d].vs + T[d].vb + T[d].va + T[d].vf;
    hst = T[d].hs + T[d].hb;
    vst = T[d].vs + T[d].vb;
    e.tag = tag;
    e.ls  = 1'b0;
    e.fs  = 1'b0;
    if (rst) begin
      m_h[d] = 0;
      m_v[d] = 0;
    end else if (en) begin
      wrap   = (m_h[d] == ht - 1);
      m_h[d] = wrap ? 0 : m_h[d] + 1;
      if (wrap) m_v[d] = (m_v[d] == vt - 1) ? 0 : m_v[d] + 1;
      e.ls = wrap;
      e.fs = wrap && (m_v[d] == 0);
    end
    e.h  = m_h[d];
    e.v  = m_v[d];
    e.hs = (m_h[d] < T[d].hs) ? T[d].pol : !T[d].pol;
    e.vs = (m_v[d] < T[d].vs) ? T[d].pol : !T[d].pol;
    e.bn = (m_h[d] >= hst) && (m_h[d] < hst + T[d].ha) &&
           (m_v[d] >= vst) && (m_v[d] < vst + T[d].va);
    e.x  = e.bn ? m_h[d] - hst : 0;
    e.y  = e.bn ? m_v[d] - vst : 0;
    if (d == 0) q_a.push_back(e);
    else q_b.push_back(e);
  endtask

  task automatic cyc_a(input bit rst_n, input bit en, input string tag);
    @(negedge clk);
    rst_a = rst_n;
    en_a  = en;
    model_step(0, !rst_n, en, tag);
  endtask

  task automatic cyc_b(input bit rst_n, input bit en, input string tag);
    @(negedge clk);
    rst_b = rst_n;
    en_b  = en;
    model_step(1, !rst_n, en, tag);
  endtask

  task automatic step_a(input bit en, input string tag);
    cyc_a(1'b1, en, tag);
    if (en) en_cnt_a++;
    @(posedge clk);
    #1;
    if (ls_a) begin
      ls_cnt++;
      chk("ls_period", en_cnt_a - last_ls, 800);
      last_ls = en_cnt_a;
    end
    if (m_v[0] == 0 && m_h[0] == 95)  chk("hsync_h95", hs_a, 0);
    if (m_v[0] == 0 && m_h[0] == 96)  chk("hsync_h96", hs_a, 1);
    if (m_v[0] == 1 && m_h[0] == 799) chk("vsync_v1", vs_a, 0);
    if (m_v[0] == 2 && m_h[0] == 0)   chk("vsync_v2", vs_a, 1);
    if (m_v[0] == 35 && m_h[0] == 143) chk("blank_h143", bn_a, 0);
    if (m_v[0] == 35 && m_h[0] == 144) begin
      chk("blank_h144", bn_a, 1);
      chk("x_h144", x_a, 0);
      chk("y_v35", y_a, 0);
    end
    if (m_v[0] == 35 && m_h[0] == 783) chk("x_h783", x_a, 639);
    if (m_v[0] == 35 && m_h[0] == 784) begin
      chk("blank_h784", bn_a, 0);
      chk("x_h784", x_a, 0);
    end
  endtask

  task automatic run_a_to(input int h, input int v);
    for (int i = 0; i < 40000 && !(m_h[0] == h && m_v[0] == v); i++) step_a(1'b1, "run");
    chk("reach_H", h_a, h);
    chk("reach_V", v_a, v);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q_a.size() > 0) begin
        ea = q_a.pop_front();
        cmp("a", ea, h_a, v_a, x_a, y_a, hs_a, vs_a, bn_a, ls_a, fs_a);
      end
      if (q_b.size() > 0) begin
        eb = q_b.pop_front();
        cmp("b", eb, h_b, v_b, x_b, y_b, hs_b, vs_b, bn_b, ls_b, fs_b);
      end
    end
  end

  initial begin
    int ls_tog, fs_cnt_b, en_cnt_b;
    bit en;
    T[0] = '{hs: 96, hb: 48, ha: 640, hf: 16, vs: 2, vb: 33, va: 480, vf: 10, pol: 1'b0};
    T[1] = '{hs: 8, hb: 4, ha: 16, hf: 4, vs: 2, vb: 1, va: 4, vf: 1, pol: 1'b1};
    m_h = '{0, 0};
    m_v = '{0, 0};
    rst_a = 1'b1; en_a = 1'b1; rst_b = 1'b1; en_b = 1'b0;
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;
    #1;
    chk("rst_H", h_a, 0);
    chk("rst_hsync", hs_a, 0);
    chk("rst_vsync", vs_a, 0);
    chk("rst_blank", bn_a, 0);
    chk("rst_b_hsync", hs_b, 1);

    repeat (3) cyc_a(1'b0, 1'b1, "reset");
    cyc_a(1'b1, 1'b1, "release");
    en_cnt_a = 1;
    @(posedge clk);
    #1;
    chk("first_H", h_a, 1);
    chk("first_fs", fs_a, 0);

    // Through the first active line and up to just before a line wrap.
    run_a_to(798, 35);
    chk("ls_count", ls_cnt, 35);

    ls_tog = 0;
    for (int i = 0; i < 8; i++) begin
      step_a((i % 2) == 0, "toggle");
      if (ls_a) ls_tog++;
    end
    chk("ls_width", ls_tog, 1);
    chk("toggle_H", h_a, 2);
    chk("toggle_V", v_a, 36);

    run_a_to(400, 36);
    @(negedge clk);
    rst_a = 1'b0;
    #1;
    chk("mid_rst_H", h_a, 0);
    chk("mid_rst_V", v_a, 0);
    chk("mid_rst_x", x_a, 0);
    chk("mid_rst_y", y_a, 0);
    chk("mid_rst_hsync", hs_a, 0);
    chk("mid_rst_vsync", vs_a, 0);
    chk("mid_rst_blank", bn_a, 0);
    model_step(0, 1'b1, 1'b1, "mid_rst");
    cyc_a(1'b0, 1'b1, "mid_rst_hold");
    cyc_a(1'b1, 1'b1, "mid_release");
    for (int i = 0; i < 5; i++) cyc_a(1'b1, 1'b1, "resume");
    @(posedge clk);
    #1;
    chk("resume_H", h_a, 6);
    chk("resume_V", v_a, 0);
    cyc_a(1'b1, 1'b0, "a_idle");

    // Small active-high instance with gappy pixel enable.
    fs_cnt_b = 0;
    cyc_b(1'b1, 1'b1, "b_release");
    en_cnt_b = 1;
    for (int i = 0; i < 2000 && fs_cnt_b < 2; i++) begin
      en = ($urandom_range(0, 3) != 0);
      cyc_b(1'b1, en, "b_run");
      if (en) en_cnt_b++;
      @(posedge clk);
      #1;
      if (fs_b) begin
        fs_cnt_b++;
        chk("b_fs_period", en_cnt_b, 256 * fs_cnt_b);
        chk("b_fs_V", v_b, 0);
      end
      if (m_h[1] == 7) chk("b_hsync_h7", hs_b, 1);
      if (m_h[1] == 8) chk("b_hsync_h8", hs_b, 0);
    end
    chk("b_fs_count", fs_cnt_b, 2);

    repeat (2) @(posedge clk);
    #2;
    chk("q_a_drained", q_a.size(), 0);
    chk("q_b_drained", q_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
